// File: rtl/mips_decode_pkg.sv
// Shared types for the MIPS decode/issue stage: op enumeration, opcode/funct/regimm codes, op-class helpers.
// DECODE_MFHI_MFLO_EN adds mfhi/mflo to the set of ops that wait on the HI/LO unit.
package mips_decode_pkg;

  localparam int OP_W = 6;

  typedef enum logic [OP_W-1:0] {
    OP_NONE = 6'd0,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
    OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW,
    OP_ILLEGAL
  } op_t;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J = 6'h02, OPC_JAL = 6'h03;
  localparam logic [5:0] OPC_BEQ = 6'h04, OPC_BNE = 6'h05, OPC_BLEZ = 6'h06, OPC_BGTZ = 6'h07;
  localparam logic [5:0] OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0A, OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D, OPC_XORI = 6'h0E, OPC_LUI = 6'h0F;
  localparam logic [5:0] OPC_LB = 6'h20, OPC_LH = 6'h21, OPC_LWL = 6'h22, OPC_LW = 6'h23;
  localparam logic [5:0] OPC_LBU = 6'h24, OPC_LHU = 6'h25, OPC_LWR = 6'h26;
  localparam logic [5:0] OPC_SB = 6'h28, OPC_SH = 6'h29, OPC_SW = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

  function automatic logic is_mem(op_t op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_branch(op_t op);
    return op inside {OP_BEQ, OP_BNE, OP_BGEZ, OP_BGEZAL, OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_BLTZAL,
                      OP_J, OP_JAL, OP_JR, OP_JALR};
  endfunction

  function automatic logic is_muldiv(op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic needs_hilo(op_t op);
`ifdef DECODE_MFHI_MFLO_EN
    return is_muldiv(op) || (op inside {OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
`else
    return is_muldiv(op) || (op inside {OP_MTHI, OP_MTLO});
`endif
  endfunction

endpackage

// File: rtl/mips_decode_comb.sv
// Purely combinational MIPS instruction decoder: raw word -> op plus register/immediate fields.
// DECODE_MFHI_MFLO_EN enables mfhi/mflo decode; otherwise those functs are illegal.
module mips_decode_comb
  import mips_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output op_t         o_op,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [15:0] o_imm,
  output logic [25:0] o_addr,
  output logic        o_illegal
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode  = i_instr[31:26];
  assign w_funct   = i_instr[5:0];
  assign o_rs      = i_instr[25:21];
  assign o_rt      = i_instr[20:16];
  assign o_rd      = i_instr[15:11];
  assign o_shamt   = i_instr[10:6];
  assign o_imm     = i_instr[15:0];
  assign o_addr    = i_instr[25:0];
  assign o_illegal = (o_op == OP_ILLEGAL);

  always_comb begin
    o_op = OP_ILLEGAL;
    case (w_opcode)
      OPC_SPECIAL: begin
        case (w_funct)
          FN_SLL:   o_op = OP_SLL;
          FN_SRL:   o_op = OP_SRL;
          FN_SRA:   o_op = OP_SRA;
          FN_SLLV:  o_op = OP_SLLV;
          FN_SRLV:  o_op = OP_SRLV;
          FN_SRAV:  o_op = OP_SRAV;
          FN_JR:    o_op = OP_JR;
          FN_JALR:  o_op = OP_JALR;
`ifdef DECODE_MFHI_MFLO_EN
          FN_MFHI:  o_op = OP_MFHI;
          FN_MFLO:  o_op = OP_MFLO;
`endif
          FN_MTHI:  o_op = OP_MTHI;
          FN_MTLO:  o_op = OP_MTLO;
          FN_MULT:  o_op = OP_MULT;
          FN_MULTU: o_op = OP_MULTU;
          FN_DIV:   o_op = OP_DIV;
          FN_DIVU:  o_op = OP_DIVU;
          FN_ADD:   o_op = OP_ADD;
          FN_ADDU:  o_op = OP_ADDU;
          FN_SUB:   o_op = OP_SUB;
          FN_SUBU:  o_op = OP_SUBU;
          FN_AND:   o_op = OP_AND;
          FN_OR:    o_op = OP_OR;
          FN_XOR:   o_op = OP_XOR;
          FN_NOR:   o_op = OP_NOR;
          FN_SLT:   o_op = OP_SLT;
          FN_SLTU:  o_op = OP_SLTU;
          default:  o_op = OP_ILLEGAL;
        endcase
      end
      OPC_REGIMM: begin
        case (o_rt)
          RT_BLTZ:   o_op = OP_BLTZ;
          RT_BGEZ:   o_op = OP_BGEZ;
          RT_BLTZAL: o_op = OP_BLTZAL;
          RT_BGEZAL: o_op = OP_BGEZAL;
          default:   o_op = OP_ILLEGAL;
        endcase
      end
      // blez/bgtz encode no second register, so a non-zero rt marks a malformed word
      OPC_BLEZ:  if (o_rt == 5'd0) o_op = OP_BLEZ;
      OPC_BGTZ:  if (o_rt == 5'd0) o_op = OP_BGTZ;
      OPC_J:     o_op = OP_J;
      OPC_JAL:   o_op = OP_JAL;
      OPC_BEQ:   o_op = OP_BEQ;
      OPC_BNE:   o_op = OP_BNE;
      OPC_ADDI:  o_op = OP_ADDI;
      OPC_ADDIU: o_op = OP_ADDIU;
      OPC_SLTI:  o_op = OP_SLTI;
      OPC_SLTIU: o_op = OP_SLTIU;
      OPC_ANDI:  o_op = OP_ANDI;
      OPC_ORI:   o_op = OP_ORI;
      OPC_XORI:  o_op = OP_XORI;
      OPC_LUI:   o_op = OP_LUI;
      OPC_LB:    o_op = OP_LB;
      OPC_LH:    o_op = OP_LH;
      OPC_LWL:   o_op = OP_LWL;
      OPC_LW:    o_op = OP_LW;
      OPC_LBU:   o_op = OP_LBU;
      OPC_LHU:   o_op = OP_LHU;
      OPC_LWR:   o_op = OP_LWR;
      OPC_SB:    o_op = OP_SB;
      OPC_SH:    o_op = OP_SH;
      OPC_SW:    o_op = OP_SW;
      default:   o_op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_decode_issue.sv
// Registered decode/issue stage: one output register with memory, HI/LO and delay-slot interlocks.
// DECODE_MFHI_MFLO_EN (via the package) makes mfhi/mflo wait for the HI/LO unit.
module mips_decode_issue
  import mips_decode_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        waitrequest,
  input  logic        out_ready,
  output logic        out_valid,
  output op_t         out_op,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [15:0] out_imm,
  output logic [25:0] out_addr,
  output logic        out_is_mem,
  output logic        out_delay_slot,
  output logic        out_illegal,
  output logic        stall,
  output logic        muldiv_busy
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t      r_state, w_stateNext;
  op_t         r_op, w_op;
  logic [4:0]  r_rs, r_rt, r_rd, r_shamt, w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] r_imm, w_imm;
  logic [25:0] r_addr, w_addr;
  logic        r_isMem, r_ds, r_dsOut, r_illegal, w_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic        w_full, w_fire, w_load, w_dsNext;

  mips_decode_comb u_decode (
    .i_instr   (in_instr),
    .o_op      (w_op),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_rd      (w_rd),
    .o_shamt   (w_shamt),
    .o_imm     (w_imm),
    .o_addr    (w_addr),
    .o_illegal (w_illegal)
  );

  assign w_full      = (r_state == ST_FULL);
  assign muldiv_busy = (r_cnt != '0);
  assign stall       = w_full & ((r_isMem & waitrequest) | (muldiv_busy & needs_hilo(r_op)));
  assign w_fire      = w_full & out_ready & ~stall;
  assign in_ready    = ~w_full | w_fire;
  assign w_load      = in_valid & in_ready;
  // A word loaded in the same cycle a branch issues is already its delay slot
  assign w_dsNext    = w_fire ? is_branch(r_op) : r_ds;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_EMPTY: if (in_valid) w_stateNext = ST_FULL;
      ST_FULL:  if (w_fire && !in_valid) w_stateNext = ST_EMPTY;
      default:  w_stateNext = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_NONE;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_imm     <= '0;
      r_addr    <= '0;
      r_isMem   <= 1'b0;
      r_dsOut   <= 1'b0;
      r_illegal <= 1'b0;
      r_ds      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_load) begin
        r_op      <= w_op;
        r_rs      <= w_rs;
        r_rt      <= w_rt;
        r_rd      <= w_rd;
        r_shamt   <= w_shamt;
        r_imm     <= w_imm;
        r_addr    <= w_addr;
        r_isMem   <= is_mem(w_op);
        r_dsOut   <= w_dsNext;
        r_illegal <= w_illegal;
      end
      r_ds <= w_dsNext;
      if (w_fire && (r_op == OP_MULT || r_op == OP_MULTU))
        r_cnt <= CNT_W'(MULT_LAT);
      else if (w_fire && (r_op == OP_DIV || r_op == OP_DIVU))
        r_cnt <= CNT_W'(DIV_LAT);
      else if (r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign out_valid      = w_full;
  assign out_op         = r_op;
  assign out_rs         = r_rs;
  assign out_rt         = r_rt;
  assign out_rd         = r_rd;
  assign out_shamt      = r_shamt;
  assign out_imm        = r_imm;
  assign out_addr       = r_addr;
  assign out_is_mem     = r_isMem;
  assign out_delay_slot = r_dsOut;
  assign out_illegal    = r_illegal;

endmodule
